// File: rtl/ca_cmd_assembler.sv
// RCD CA front end: captures DCA/DPAR/DCS_n, frames 1-/2-UI commands, checks per-UI parity,
// blocks errored commands and drives ALERT_n; clean UIs leave with a fixed 3-stage latency.
module ca_cmd_assembler #(
  parameter int CA_WIDTH  = 7,
  parameter int NUM_RANKS = 2,
  parameter int ALERT_PW  = 8,
  parameter int BLOCK_CYC = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_RANKS-1:0] dcs_n,
  input  logic [CA_WIDTH-1:0]  dca,
  input  logic                 dpar,
  input  logic                 par_enable,
  input  logic                 err_clr,
  output logic [CA_WIDTH-1:0]  ca_out,
  output logic                 ca_valid_out,
  output logic                 ca_ui1,
  output logic [NUM_RANKS-1:0] rank_enable,
  output logic                 alert_n,
  output logic                 err_sticky,
  output logic [7:0]           err_count
);

  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_WAIT_UI1 = 1'b1;

  localparam int AW = $clog2(ALERT_PW + 1);
  localparam int BW = $clog2(BLOCK_CYC + 2);

  logic [0:0]           state_q, state_d;
  logic [CA_WIDTH-1:0]  s1_data_q, s1_data_d;
  logic                 s1_ok_q, s1_ok_d;
  logic                 s1_cs_q, s1_cs_d;
  logic [NUM_RANKS-1:0] s1_rank_q, s1_rank_d;
  logic [CA_WIDTH-1:0]  s2_data_q, s2_data_d;
  logic                 s2_ok_q, s2_ok_d;
  logic [NUM_RANKS-1:0] s2_rank_q, s2_rank_d;
  logic                 s2_pass_q, s2_pass_d;
  logic                 s2_ui1_q, s2_ui1_d;
  logic [CA_WIDTH-1:0]  ca_out_q, ca_out_d;
  logic                 ca_valid_q, ca_valid_d;
  logic                 ca_ui1_q, ca_ui1_d;
  logic [NUM_RANKS-1:0] rank_q, rank_d;
  logic [AW-1:0]        alert_cnt_q, alert_cnt_d;
  logic                 alert_n_q, alert_n_d;
  logic [BW-1:0]        blk_cnt_q, blk_cnt_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [7:0]           err_count_q, err_count_d;

  logic       blocked;
  logic       decide;
  logic       good;
  logic       issue_ui0;
  logic       err;
  logic [7:0] cnt_base;

  always_comb begin
    s1_data_d = dca;
    s1_ok_d   = !par_enable || !(^{dca, dpar});
    s1_cs_d   = |(~dcs_n);
    s1_rank_d = ~dcs_n;

    blocked   = (blk_cnt_q != '0);
    decide    = 1'b0;
    good      = 1'b0;
    issue_ui0 = 1'b0;
    state_d   = state_q;
    s2_data_d = s1_data_q;
    s2_ok_d   = s1_ok_q;
    s2_rank_d = s1_rank_q;
    s2_pass_d = 1'b0;
    s2_ui1_d  = 1'b0;

    // In WAIT_UI1, s1 holds UI1 and s2 holds the already-captured UI0, so both
    // UIs' parity is visible in the same cycle and UI0 is issued straight from s2.
    if (state_q == ST_WAIT_UI1) begin
      decide    = 1'b1;
      good      = s2_ok_q && s1_ok_q;
      issue_ui0 = good;
      s2_pass_d = good;
      s2_ui1_d  = 1'b1;
      s2_rank_d = s2_rank_q;
      state_d   = ST_IDLE;
    end else if (s1_cs_q && !blocked) begin
      if (!s1_data_q[1]) begin
        state_d = ST_WAIT_UI1;
      end else begin
        decide    = 1'b1;
        good      = s1_ok_q;
        s2_pass_d = good;
      end
    end

    err = decide && !good;

    ca_valid_d = 1'b0;
    ca_out_d   = ca_out_q;
    ca_ui1_d   = ca_ui1_q;
    rank_d     = rank_q;
    if (issue_ui0) begin
      ca_valid_d = 1'b1;
      ca_out_d   = s2_data_q;
      ca_ui1_d   = 1'b0;
      rank_d     = s2_rank_q;
    end else if (s2_pass_q) begin
      ca_valid_d = 1'b1;
      ca_out_d   = s2_data_q;
      ca_ui1_d   = s2_ui1_q;
      rank_d     = s2_rank_q;
    end

    // A clear and an error in the same cycle leave the count at one.
    cnt_base     = err_clr ? '0 : err_count_q;
    err_count_d  = cnt_base;
    if (err && (cnt_base != 8'hFF)) err_count_d = cnt_base + 8'd1;
    err_sticky_d = err ? 1'b1 : (err_clr ? 1'b0 : err_sticky_q);

    if (err)                     alert_cnt_d = AW'(ALERT_PW);
    else if (alert_cnt_q != '0)  alert_cnt_d = alert_cnt_q - AW'(1);
    else                         alert_cnt_d = '0;
    alert_n_d = (alert_cnt_d == '0);

    if (err)                     blk_cnt_d = BW'(BLOCK_CYC);
    else if (blocked)            blk_cnt_d = blk_cnt_q - BW'(1);
    else                         blk_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      s1_data_q    <= '0;
      s1_ok_q      <= 1'b1;
      s1_cs_q      <= 1'b0;
      s1_rank_q    <= '0;
      s2_data_q    <= '0;
      s2_ok_q      <= 1'b1;
      s2_rank_q    <= '0;
      s2_pass_q    <= 1'b0;
      s2_ui1_q     <= 1'b0;
      ca_out_q     <= '0;
      ca_valid_q   <= 1'b0;
      ca_ui1_q     <= 1'b0;
      rank_q       <= '0;
      alert_cnt_q  <= '0;
      alert_n_q    <= 1'b1;
      blk_cnt_q    <= '0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      s1_data_q    <= s1_data_d;
      s1_ok_q      <= s1_ok_d;
      s1_cs_q      <= s1_cs_d;
      s1_rank_q    <= s1_rank_d;
      s2_data_q    <= s2_data_d;
      s2_ok_q      <= s2_ok_d;
      s2_rank_q    <= s2_rank_d;
      s2_pass_q    <= s2_pass_d;
      s2_ui1_q     <= s2_ui1_d;
      ca_out_q     <= ca_out_d;
      ca_valid_q   <= ca_valid_d;
      ca_ui1_q     <= ca_ui1_d;
      rank_q       <= rank_d;
      alert_cnt_q  <= alert_cnt_d;
      alert_n_q    <= alert_n_d;
      blk_cnt_q    <= blk_cnt_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
    end
  end

  assign ca_out       = ca_out_q;
  assign ca_valid_out = ca_valid_q;
  assign ca_ui1       = ca_ui1_q;
  assign rank_enable  = rank_q;
  assign alert_n      = alert_n_q;
  assign err_sticky   = err_sticky_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_ca_cmd_assembler.sv
// Bench for ca_cmd_assembler: edge-indexed command model plus directed literal checks.
module tb_ca_cmd_assembler;
  localparam int CA_WIDTH  = 7;
  localparam int NUM_RANKS = 2;
  localparam int ALERT_PW  = 8;
  localparam int BLOCK_CYC = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NUM_RANKS-1:0] dcs_n;
  logic [CA_WIDTH-1:0]  dca;
  logic                 dpar;
  logic                 par_enable;
  logic                 err_clr;
  logic [CA_WIDTH-1:0]  ca_out;
  logic                 ca_valid_out;
  logic                 ca_ui1;
  logic [NUM_RANKS-1:0] rank_enable;
  logic                 alert_n;
  logic                 err_sticky;
  logic [7:0]           err_count;

  always #5 clk = ~clk;

  ca_cmd_assembler #(
    .CA_WIDTH (CA_WIDTH),
    .NUM_RANKS(NUM_RANKS),
    .ALERT_PW (ALERT_PW),
    .BLOCK_CYC(BLOCK_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dcs_n       (dcs_n),
    .dca         (dca),
    .dpar        (dpar),
    .par_enable  (par_enable),
    .err_clr     (err_clr),
    .ca_out      (ca_out),
    .ca_valid_out(ca_valid_out),
    .ca_ui1      (ca_ui1),
    .rank_enable (rank_enable),
    .alert_n     (alert_n),
    .err_sticky  (err_sticky),
    .err_count   (err_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: each captured UI is tagged with its edge number; outputs land two edges later,
  // error effects start one edge after the decision and last a fixed number of edges.
  typedef struct {
    bit       v;
    bit [6:0] ca;
    bit       ui1;
    bit [1:0] rank;
  } out_t;

  out_t     obuf [4];
  out_t     exp_out;
  bit       exp_alert_n;
  bit       m_live    = 1'b0;
  int       e_now     = 0;
  bit       pend_ui1  = 1'b0;
  bit [6:0] p0_ca;
  bit       p0_ok;
  bit [1:0] p0_rank;
  bit       err_pend  = 1'b0;
  bit       have_err  = 1'b0;
  int       last_err  = 0;
  int       m_cnt     = 0;
  bit       m_sticky  = 1'b0;

  function automatic bit ui_ok(input bit pe, input bit [6:0] d, input bit p);
    return !pe || ((^{d, p}) == 1'b0);
  endfunction

  task automatic model_edge();
    bit ok;
    e_now++;
    if (rst) begin
      for (int i = 0; i < 4; i++) obuf[i] = '{default: 0};
      exp_out     = '{default: 0};
      exp_alert_n = 1'b1;
      pend_ui1    = 1'b0;
      err_pend    = 1'b0;
      have_err    = 1'b0;
      m_cnt       = 0;
      m_sticky    = 1'b0;
      m_live      = 1'b1;
      return;
    end
    exp_out         = obuf[e_now % 4];
    obuf[e_now % 4] = '{default: 0};
    if (err_clr) begin
      m_cnt    = 0;
      m_sticky = 1'b0;
    end
    if (err_pend) begin
      if (m_cnt < 255) m_cnt++;
      m_sticky = 1'b1;
      have_err = 1'b1;
      last_err = e_now;
      err_pend = 1'b0;
    end
    exp_alert_n = !(have_err && (e_now - last_err) < ALERT_PW);
    ok = ui_ok(par_enable, dca, dpar);
    if (pend_ui1) begin
      pend_ui1 = 1'b0;
      if (p0_ok && ok) begin
        obuf[(e_now + 1) % 4] = '{1'b1, p0_ca, 1'b0, p0_rank};
        obuf[(e_now + 2) % 4] = '{1'b1, dca, 1'b1, p0_rank};
      end else begin
        err_pend = 1'b1;
      end
    end else if (dcs_n != 2'b11 && !(have_err && (e_now - last_err) < BLOCK_CYC)) begin
      if (!dca[1]) begin
        pend_ui1 = 1'b1;
        p0_ca    = dca;
        p0_ok    = ok;
        p0_rank  = ~dcs_n;
      end else if (ok) begin
        obuf[(e_now + 2) % 4] = '{1'b1, dca, 1'b0, ~dcs_n};
      end else begin
        err_pend = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    if (m_live) begin
      chk("valid", int'(ca_valid_out), int'(exp_out.v));
      if (exp_out.v) begin
        chk("ca_out", int'(ca_out), int'(exp_out.ca));
        chk("ca_ui1", int'(ca_ui1), int'(exp_out.ui1));
        chk("rank_enable", int'(rank_enable), int'(exp_out.rank));
      end
      chk("alert_n", int'(alert_n), int'(exp_alert_n));
      chk("err_count", int'(err_count), m_cnt);
      chk("err_sticky", int'(err_sticky), int'(m_sticky));
    end
  end

  task automatic step(input logic [1:0] cs, input logic [6:0] d, input logic p,
                      input logic pe = 1'b1, input logic clr = 1'b0, input logic r = 1'b0);
    dcs_n      = cs;
    dca        = d;
    dpar       = p;
    par_enable = pe;
    err_clr    = clr;
    rst        = r;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(2'b11, 7'h00, 1'b0);
  endtask

  initial begin
    rst = 1'b1; dcs_n = 2'b11; dca = '0; dpar = 1'b0; par_enable = 1'b1; err_clr = 1'b0;
    step(2'b11, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    step(2'b11, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rst_ca_out", int'(ca_out), 0);
    chk("rst_valid", int'(ca_valid_out), 0);
    chk("rst_ui1", int'(ca_ui1), 0);
    chk("rst_rank", int'(rank_enable), 0);
    chk("rst_alert_n", int'(alert_n), 1);
    chk("rst_sticky", int'(err_sticky), 0);
    chk("rst_count", int'(err_count), 0);
    idle(2);

    // 1-UI command, latency check
    step(2'b10, 7'h03, 1'b0);
    idle(1);
    chk("t1_early_valid", int'(ca_valid_out), 0);
    idle(1);
    chk("t1_ca", int'(ca_out), 'h03);
    chk("t1_valid", int'(ca_valid_out), 1);
    chk("t1_ui1", int'(ca_ui1), 0);
    chk("t1_rank", int'(rank_enable), 'b01);
    idle(3);

    // 2-UI command
    step(2'b00, 7'h00, 1'b0);
    step(2'b00, 7'h15, 1'b1);
    idle(1);
    chk("t2_ui0_ca", int'(ca_out), 'h00);
    chk("t2_ui0_valid", int'(ca_valid_out), 1);
    chk("t2_ui0_rank", int'(rank_enable), 'b11);
    chk("t2_ui0_ui1", int'(ca_ui1), 0);
    idle(1);
    chk("t2_ui1_ca", int'(ca_out), 'h15);
    chk("t2_ui1_ui1", int'(ca_ui1), 1);
    chk("t2_ui1_rank", int'(rank_enable), 'b11);
    idle(3);

    // parity error on UI1, then block window boundary
    step(2'b00, 7'h00, 1'b0);
    step(2'b11, 7'h15, 1'b0);
    idle(1);
    chk("t3_alert_start", int'(alert_n), 0);
    chk("t3_count", int'(err_count), 1);
    chk("t3_sticky", int'(err_sticky), 1);
    idle(7);
    chk("t3_alert_last", int'(alert_n), 0);
    idle(1);
    chk("t3_alert_end", int'(alert_n), 1);
    idle(6);
    step(2'b10, 7'h06, 1'b0);
    step(2'b10, 7'h0A, 1'b0);
    idle(1);
    chk("t3_blocked", int'(ca_valid_out), 0);
    idle(1);
    chk("t3_after_ca", int'(ca_out), 'h0A);
    chk("t3_after_valid", int'(ca_valid_out), 1);
    idle(3);

    // parity disabled, and par_enable changing within a command
    step(2'b11, 7'h00, 1'b0, 1'b1, 1'b1);
    chk("t4_clr_count", int'(err_count), 0);
    step(2'b10, 7'h03, 1'b1, 1'b0);
    idle(2);
    chk("t4_ca", int'(ca_out), 'h03);
    chk("t4_valid", int'(ca_valid_out), 1);
    chk("t4_alert_n", int'(alert_n), 1);
    chk("t4_count", int'(err_count), 0);
    step(2'b01, 7'h00, 1'b1, 1'b0);
    step(2'b01, 7'h15, 1'b1, 1'b1);
    idle(4);

    // counter saturation and clear-vs-error priority
    for (int i = 0; i < 256; i++) begin
      step(2'b10, 7'h02, 1'b0);
      idle(BLOCK_CYC);
    end
    chk("t5_sat", int'(err_count), 255);
    step(2'b10, 7'h02, 1'b0);
    step(2'b11, 7'h00, 1'b0, 1'b1, 1'b1);
    chk("t5_clr_err_count", int'(err_count), 1);
    chk("t5_clr_err_sticky", int'(err_sticky), 1);
    idle(BLOCK_CYC + 1);
    step(2'b11, 7'h00, 1'b0, 1'b1, 1'b1);
    chk("t5_clr_only", int'(err_count), 0);
    idle(2);

    // reset in the middle of a 2-UI command and with an output in flight
    step(2'b00, 7'h00, 1'b0);
    step(2'b11, 7'h15, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("t6_valid", int'(ca_valid_out), 0);
    chk("t6_rank", int'(rank_enable), 0);
    step(2'b11, 7'h15, 1'b1);
    idle(3);
    step(2'b10, 7'h0B, 1'b1);
    step(2'b11, 7'h00, 1'b0);
    step(2'b11, 7'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("t6_drop_valid", int'(ca_valid_out), 0);
    chk("t6_drop_ca", int'(ca_out), 0);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
